// File: rtl/up_down_counter_param_pkg.sv
// rtl/up_down_counter_param_pkg.sv - shared constants and load-clamp helper for the up/down counter
package up_down_counter_param_pkg;

   // Direction encoding on the mode input
   localparam logic UDC_UP   = 1'b1;
   localparam logic UDC_DOWN = 1'b0;

   // Boundary behaviour encoding on the sat input
   localparam logic UDC_WRAP = 1'b0;
   localparam logic UDC_SAT  = 1'b1;

   // Limit a value to the top of the count range; callers size-cast to WIDTH (WIDTH <= 32)
   function automatic logic [31:0] udc_clamp(input logic [31:0] value, input logic [31:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/udc_next_val.sv
// rtl/udc_next_val.sv - combinational next count and boundary detection for one enabled step
module udc_next_val
   import up_down_counter_param_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] count,
   input  logic             mode,
   input  logic             sat,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] next_count,
   output logic             boundary_hit
);

   // Boundary is checked before any arithmetic so MAX_VAL = 2**WIDTH-1 never loses a carry
   always_comb begin
      next_count   = count;
      boundary_hit = 1'b0;
      if (mode == UDC_UP) begin
         if (count >= max_val) begin
            boundary_hit = 1'b1;
            next_count   = (sat == UDC_SAT) ? max_val : '0;
         end else begin
            next_count = count + WIDTH'(1);
         end
      end else begin
         if (count == '0) begin
            boundary_hit = 1'b1;
            next_count   = (sat == UDC_SAT) ? '0 : max_val;
         end else begin
            next_count = count - WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - up/down counter with load, modulo, wrap/saturate, tc pulse; optional sticky ovf via UDC_OVF_STICKY_EN
module up_down_counter_param
   import up_down_counter_param_pkg::*;
#(
   parameter int          WIDTH   = 8,
   parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             mode,
   input  logic             sat,
   input  logic             ld,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] count,
   output logic             tc,
`ifdef UDC_OVF_STICKY_EN
   output logic             ovf,
`endif
   output logic             at_min,
   output logic             at_max
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] next_count;
   logic             boundary_hit;
   logic [WIDTH-1:0] load_val;

   udc_next_val #(.WIDTH(WIDTH)) u_next_val (
      .count        (count),
      .mode         (mode),
      .sat          (sat),
      .max_val      (MAX_W),
      .next_count   (next_count),
      .boundary_hit (boundary_hit)
   );

   // Out-of-range loads land on the top of the range
   assign load_val = WIDTH'(udc_clamp(32'(d_in), 32'(MAX_VAL)));

   // Count and terminal-count registers with clear > ld > en priority
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (ld) begin
         count <= load_val;
         tc    <= 1'b0;
      end else if (en) begin
         count <= next_count;
         tc    <= boundary_hit;
      end else begin
         tc    <= 1'b0;
      end
   end

`ifdef UDC_OVF_STICKY_EN
   // Sticky overflow: set with tc, survives loads, only clear resets it
   always_ff @(posedge clk) begin
      if (clear) begin
         ovf <= 1'b0;
      end else if (!ld && en && boundary_hit) begin
         ovf <= 1'b1;
      end
   end
`endif

   assign at_min = (count == '0);
   assign at_max = (count == MAX_W);

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - randomized and directed self-checking bench for up_down_counter_param
module tb_up_down_counter_param;

   localparam int WIDTH = 4;
   localparam int MAXV  = 9;

   logic             clk = 1'b0;
   logic             clear = 1'b0, en = 1'b0, mode = 1'b0, sat = 1'b0, ld = 1'b0;
   logic [WIDTH-1:0] d_in = '0;
   logic [WIDTH-1:0] count;
   logic             tc, at_min, at_max;
`ifdef UDC_OVF_STICKY_EN
   logic             ovf;
`endif

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // reference model state
   int m_count = 0;
   int m_tc = 0;
   int m_ovf = 0;

   up_down_counter_param #(.WIDTH(WIDTH), .MAX_VAL(MAXV)) dut (
      .clk    (clk),
      .clear  (clear),
      .en     (en),
      .mode   (mode),
      .sat    (sat),
      .ld     (ld),
      .d_in   (d_in),
      .count  (count),
      .tc     (tc),
`ifdef UDC_OVF_STICKY_EN
      .ovf    (ovf),
`endif
      .at_min (at_min),
      .at_max (at_max)
   );

   always #5 clk = ~clk;

   // reference model: modular arithmetic on a plain integer
   always @(posedge clk) begin
      int hit;
      if (clear) begin
         m_count = 0; m_tc = 0; m_ovf = 0;
      end else if (ld) begin
         m_count = (int'(d_in) > MAXV) ? MAXV : int'(d_in);
         m_tc = 0;
      end else if (en) begin
         hit = mode ? int'(m_count == MAXV) : int'(m_count == 0);
         m_tc = hit;
         if (hit != 0) m_ovf = 1;
         if (hit != 0 && sat) m_count = m_count;
         else if (mode) m_count = (m_count + 1) % (MAXV + 1);
         else m_count = (m_count + MAXV) % (MAXV + 1);
      end else begin
         m_tc = 0;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (int'(count) != m_count || int'(tc) != m_tc ||
             int'(at_min) != int'(m_count == 0) || int'(at_max) != int'(m_count == MAXV)) begin
            fails++;
            $display("FAIL model t=%0t count=%0d tc=%0d min=%0d max=%0d required count=%0d tc=%0d",
                     $time, count, tc, at_min, at_max, m_count, m_tc);
         end
`ifdef UDC_OVF_STICKY_EN
         tests++;
         if (int'(ovf) != m_ovf) begin
            fails++;
            $display("FAIL model_ovf t=%0t ovf=%0d required %0d", $time, ovf, m_ovf);
         end
`endif
      end
   end

   task automatic cyc(input logic c, input logic l, input int d, input logic e,
                      input logic m, input logic s);
      clear = c; ld = l; d_in = WIDTH'(d); en = e; mode = m; sat = s;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_ct(input string name, input int c, input int t);
      chk({name, "_count"}, int'(count), c);
      chk({name, "_tc"}, int'(tc), t);
   endtask

   initial begin
      // 1: reset and first load
      cyc(1, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      cyc(1, 1, 5, 1, 1, 0);
      chk_ct("reset", 0, 0);
      chk("reset_at_min", int'(at_min), 1);
      chk("reset_at_max", int'(at_max), 0);
      cyc(0, 1, 7, 0, 0, 0);
      chk_ct("load7", 7, 0);

      // 2: wrap upward
      cyc(0, 0, 0, 1, 1, 0); chk_ct("up8", 8, 0);
      cyc(0, 0, 0, 1, 1, 0); chk_ct("up9", 9, 0);
      chk("up9_at_max", int'(at_max), 1);
      cyc(0, 0, 0, 1, 1, 0); chk_ct("upwrap0", 0, 1);
`ifdef UDC_OVF_STICKY_EN
      chk("ovf_set", int'(ovf), 1);
`endif
      cyc(0, 0, 0, 1, 1, 0); chk_ct("up1", 1, 0);

      // 3: wrap downward
      cyc(0, 0, 0, 1, 0, 0); chk_ct("dn0", 0, 0);
      cyc(0, 0, 0, 1, 0, 0); chk_ct("dnwrap9", 9, 1);
      cyc(0, 0, 0, 1, 0, 0); chk_ct("dn8", 8, 0);

      // 4: saturate at top
      cyc(0, 1, 9, 0, 1, 1); chk_ct("ld9", 9, 0);
`ifdef UDC_OVF_STICKY_EN
      chk("ovf_survives_ld", int'(ovf), 1);
`endif
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1, 1, 1); chk_ct("sat9", 9, 1);
      end
      cyc(0, 0, 0, 1, 0, 1); chk_ct("sat_dn8", 8, 0);

      // 5: clamp, load priority, clear priority
      cyc(0, 1, 14, 0, 0, 0); chk_ct("clamp", 9, 0);
      cyc(0, 1, 3, 1, 1, 0);  chk_ct("ld_over_en", 3, 0);
      cyc(1, 1, 5, 1, 1, 0);  chk_ct("clr_over_ld", 0, 0);
`ifdef UDC_OVF_STICKY_EN
      chk("ovf_cleared", int'(ovf), 0);
`endif
      // clear at the down boundary must not produce tc
      cyc(1, 0, 0, 1, 0, 0);  chk_ct("clr_no_tc", 0, 0);

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 40) == 0, ($urandom % 8) == 0, int'($urandom_range(0, 15)),
             ($urandom % 4) != 0, $urandom % 2 == 1, $urandom % 2 == 1);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
